// File: rtl/spi_slave_reg_bridge_pkg.sv
// spi_slave_reg_bridge_pkg: shared state encodings, protocol constants and helpers
package spi_slave_reg_bridge_pkg;
    typedef enum logic [2:0] {IDLE, CMD, WR_DATA, RD_FETCH, RD_CAP, RD_WAIT} state_t;
    localparam int CMD_RW_BIT = 7;
    localparam logic [3:0] ERR_CNT_MAX = 4'd15;
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == ERR_CNT_MAX) ? v : v + 4'd1;
    endfunction
endpackage

// File: rtl/spi_slave_reg_bridge_sync.sv
// spi_sync_ff: multi-flop synchronizer bringing an async level into the PCLK domain
module spi_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[STAGES-2:0], d};
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) sync_q <= '0;
        else sync_q <= sync_d;
    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/spi_slave_reg_bridge.sv
// spi_slave_reg_bridge: decodes SPI command bytes into register-bus reads/writes in PCLK domain
// and returns read data to the SCK-side shifter as TX_DATA plus a SPI_RDY load strobe.
module spi_slave_reg_bridge
    import spi_slave_reg_bridge_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RDY_CYCLES  = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              SS,
    input  logic [DATA_W-1:0] RX_BYTE,
    input  logic              RX_TOGGLE,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              SPI_RDY,
    output logic [ADDR_W-1:0] REG_ADDR,
    output logic [DATA_W-1:0] REG_WDATA,
    output logic              REG_WR,
    output logic              REG_RD,
    input  logic [DATA_W-1:0] REG_RDATA,
    output logic              BUSY,
    output logic [3:0]        ERR_CNT
);
    localparam int CW = $clog2(RDY_CYCLES + 1);
    logic ss_s, tog_s, evt_raw;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] rx_q, rx_d, tx_q, tx_d, reg_wdata_q, reg_wdata_d;
    logic [CW-1:0] rdy_cnt_q, rdy_cnt_d;
    logic [3:0] err_q, err_d;
    logic tog_prev_q, tog_prev_d, evt_q, evt_d, ss_q, ss_d, got_q, got_d;
    logic spi_rdy_q, spi_rdy_d, reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d;

    spi_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ss  (.PCLK(PCLK), .PRESETn(PRESETn), .d(SS),        .q(ss_s));
    spi_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_tog (.PCLK(PCLK), .PRESETn(PRESETn), .d(RX_TOGGLE), .q(tog_s));

    always_comb begin
        evt_raw     = tog_s != tog_prev_q;
        tog_prev_d  = tog_s;
        evt_d       = evt_raw;
        ss_d        = ss_s;
        rx_d        = evt_raw ? RX_BYTE : rx_q;
        state_d     = state_q;
        addr_d      = addr_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        tx_d        = tx_q;
        err_d       = err_q;
        got_d       = got_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        spi_rdy_d   = (state_q == RD_CAP) || (spi_rdy_q && rdy_cnt_q != '0);
        rdy_cnt_d   = (state_q == RD_CAP) ? CW'(RDY_CYCLES - 1) :
                      (rdy_cnt_q != '0) ? rdy_cnt_q - 1'b1 : rdy_cnt_q;
        // frame end wins over a same-cycle byte event; strobes already issued still complete
        if (state_q != IDLE && ss_q) begin
            state_d   = IDLE;
            spi_rdy_d = 1'b0;
            rdy_cnt_d = '0;
            if ((state_q == WR_DATA && !got_q) || state_q == RD_FETCH || state_q == RD_CAP)
                err_d = sat_inc(err_q);
        end else begin
            case (state_q)
                IDLE: state_d = ss_q ? IDLE : CMD;
                CMD: if (evt_q) begin
                    addr_d   = rx_q[ADDR_W-1:0];
                    got_d    = 1'b0;
                    state_d  = rx_q[CMD_RW_BIT] ? RD_FETCH : WR_DATA;
                    reg_rd_d = rx_q[CMD_RW_BIT];
                    reg_addr_d = rx_q[CMD_RW_BIT] ? rx_q[ADDR_W-1:0] : reg_addr_q;
                end
                WR_DATA: if (evt_q) begin
                    reg_wr_d    = 1'b1;
                    reg_addr_d  = addr_q;
                    reg_wdata_d = rx_q;
                    addr_d      = addr_q + 1'b1;
                    got_d       = 1'b1;
                end
                RD_FETCH: begin
                    state_d = RD_CAP;
                    err_d   = evt_q ? sat_inc(err_q) : err_q;
                end
                RD_CAP: begin
                    state_d = RD_WAIT;
                    tx_d    = REG_RDATA;
                    err_d   = evt_q ? sat_inc(err_q) : err_q;
                end
                RD_WAIT: if (evt_q) begin
                    addr_d     = addr_q + 1'b1;
                    reg_addr_d = addr_q + 1'b1;
                    reg_rd_d   = 1'b1;
                    state_d    = RD_FETCH;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rdy_cnt_q   <= '0;
            err_q       <= '0;
            tog_prev_q  <= 1'b0;
            evt_q       <= 1'b0;
            ss_q        <= 1'b0;
            got_q       <= 1'b0;
            spi_rdy_q   <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rdy_cnt_q   <= rdy_cnt_d;
            err_q       <= err_d;
            tog_prev_q  <= tog_prev_d;
            evt_q       <= evt_d;
            ss_q        <= ss_d;
            got_q       <= got_d;
            spi_rdy_q   <= spi_rdy_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
        end

    assign TX_DATA   = tx_q;
    assign SPI_RDY   = spi_rdy_q;
    assign REG_ADDR  = reg_addr_q;
    assign REG_WDATA = reg_wdata_q;
    assign REG_WR    = reg_wr_q;
    assign REG_RD    = reg_rd_q;
    assign BUSY      = state_q != IDLE;
    assign ERR_CNT   = err_q;
endmodule

// File: tb/tb_spi_slave_reg_bridge.sv
// tb_spi_slave_reg_bridge: table-driven frame vectors plus directed latency/abort/collision/reset sequences
module tb_spi_slave_reg_bridge;
    logic clk = 1'b0, PRESETn = 1'b0, SS = 1'b1, RX_TOGGLE = 1'b0;
    logic [7:0] RX_BYTE = 8'h00, REG_RDATA = 8'h00;
    logic [7:0] TX_DATA, REG_WDATA;
    logic [6:0] REG_ADDR;
    logic SPI_RDY, REG_WR, REG_RD, BUSY;
    logic [3:0] ERR_CNT;
    int n_chk = 0, n_err = 0;

    spi_slave_reg_bridge dut (
        .PCLK(clk), .PRESETn(PRESETn), .SS(SS), .RX_BYTE(RX_BYTE), .RX_TOGGLE(RX_TOGGLE),
        .TX_DATA(TX_DATA), .SPI_RDY(SPI_RDY), .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA),
        .REG_WR(REG_WR), .REG_RD(REG_RD), .REG_RDATA(REG_RDATA), .BUSY(BUSY), .ERR_CNT(ERR_CNT)
    );

    always #5 clk = ~clk;

    // register file stand-in: read data is address ^ 0x3F, valid the cycle after REG_RD
    always @(posedge clk) if (REG_RD) REG_RDATA <= {1'b0, REG_ADDR} ^ 8'h3F;

    logic [6:0] wr_a[$], rd_a[$];
    logic [7:0] wr_d[$];
    int rdy_tot = 0, rdy_run = 0, rdy_max = 0, both_hi = 0;
    always @(negedge clk) begin
        if (REG_WR) begin wr_a.push_back(REG_ADDR); wr_d.push_back(REG_WDATA); end
        if (REG_RD) rd_a.push_back(REG_ADDR);
        if (REG_WR && REG_RD) both_hi++;
        if (SPI_RDY) begin rdy_tot++; rdy_run++; if (rdy_run > rdy_max) rdy_max = rdy_run; end
        else rdy_run = 0;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        PRESETn = 1'b0; SS = 1'b1; RX_TOGGLE = 1'b0;
        repeat (3) @(negedge clk);
        PRESETn = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_start();
        @(negedge clk); SS = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk); SS = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); RX_BYTE = b; RX_TOGGLE = ~RX_TOGGLE;
        repeat (16) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        int nb, wr_n;
        logic [6:0] wa0; logic [7:0] wd0;
        logic [6:0] wa1; logic [7:0] wd1;
        int rd_n;
        logic [6:0] ra0, ra1;
        logic [7:0] tx;
        int rdy;
        logic [3:0] err;
    } vec_t;

    vec_t v[8];

    initial begin
        int wb, rb, yb, n;
        //         b0     b1     b2    nb wr  wa0    wd0    wa1    wd1   rd  ra0    ra1    tx    rdy err
        v[0] = '{8'h05, 8'hA5, 8'h00, 2, 1, 7'h05, 8'hA5, 7'h05, 8'hA5, 0, 7'h00, 7'h00, 8'h00, 0, 4'd0};
        v[1] = '{8'h7F, 8'h11, 8'h22, 3, 2, 7'h7F, 8'h11, 7'h00, 8'h22, 0, 7'h00, 7'h00, 8'h00, 0, 4'd0};
        v[2] = '{8'h83, 8'h00, 8'h00, 2, 0, 7'h00, 8'h00, 7'h00, 8'h00, 2, 7'h03, 7'h04, 8'h3B, 4, 4'd0};
        v[3] = '{8'h10, 8'h00, 8'h00, 1, 0, 7'h00, 8'h00, 7'h00, 8'h00, 0, 7'h00, 7'h00, 8'h00, 0, 4'd1};
        v[4] = '{8'h85, 8'h00, 8'h00, 1, 0, 7'h00, 8'h00, 7'h00, 8'h00, 1, 7'h05, 7'h05, 8'h3A, 2, 4'd0};
        v[5] = '{8'hFF, 8'h00, 8'h00, 2, 0, 7'h00, 8'h00, 7'h00, 8'h00, 2, 7'h7F, 7'h00, 8'h3F, 4, 4'd0};
        v[6] = '{8'h20, 8'h5A, 8'h6B, 3, 2, 7'h20, 8'h5A, 7'h21, 8'h6B, 0, 7'h00, 7'h00, 8'h00, 0, 4'd0};
        v[7] = '{8'h00, 8'h00, 8'h00, 0, 0, 7'h00, 8'h00, 7'h00, 8'h00, 0, 7'h00, 7'h00, 8'h00, 0, 4'd0};

        do_reset();
        chk("reset_busy", BUSY, 0);
        chk("reset_err", ERR_CNT, 0);
        chk("reset_tx", TX_DATA, 0);
        chk("reset_rdy", SPI_RDY, 0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            wb = wr_a.size(); rb = rd_a.size(); yb = rdy_tot;
            frame_start();
            if (v[i].nb > 0) send_byte(v[i].b0);
            if (v[i].nb > 1) send_byte(v[i].b1);
            if (v[i].nb > 2) send_byte(v[i].b2);
            frame_end();
            chk($sformatf("v%0d_wr_n", i), wr_a.size() - wb, v[i].wr_n);
            if (wr_a.size() - wb == v[i].wr_n && v[i].wr_n > 0) begin
                chk($sformatf("v%0d_wa0", i), wr_a[wb], v[i].wa0);
                chk($sformatf("v%0d_wd0", i), wr_d[wb], v[i].wd0);
                chk($sformatf("v%0d_wa1", i), wr_a[wr_a.size()-1], v[i].wa1);
                chk($sformatf("v%0d_wd1", i), wr_d[wr_d.size()-1], v[i].wd1);
            end
            chk($sformatf("v%0d_rd_n", i), rd_a.size() - rb, v[i].rd_n);
            if (rd_a.size() - rb == v[i].rd_n && v[i].rd_n > 0) begin
                chk($sformatf("v%0d_ra0", i), rd_a[rb], v[i].ra0);
                chk($sformatf("v%0d_ra1", i), rd_a[rd_a.size()-1], v[i].ra1);
            end
            chk($sformatf("v%0d_tx", i), TX_DATA, v[i].tx);
            chk($sformatf("v%0d_rdy_cycles", i), rdy_tot - yb, v[i].rdy);
            chk($sformatf("v%0d_err", i), ERR_CNT, v[i].err);
            chk($sformatf("v%0d_busy", i), BUSY, 0);
        end

        // toggle edge -> REG_WR: sync stages + event register + strobe register
        do_reset();
        frame_start();
        send_byte(8'h05);
        @(negedge clk); RX_BYTE = 8'hA5; RX_TOGGLE = ~RX_TOGGLE;
        n = 0;
        while (n < 20 && !REG_WR) begin @(negedge clk); n++; end
        chk("lat_wr", n, 4);
        chk("lat_wdata", REG_WDATA, 8'hA5);
        frame_end();

        // command toggle -> SPI_RDY rise
        do_reset();
        frame_start();
        @(negedge clk); RX_BYTE = 8'h83; RX_TOGGLE = ~RX_TOGGLE;
        n = 0;
        while (n < 20 && !SPI_RDY) begin @(negedge clk); n++; end
        chk("lat_rdy", n, 6);
        chk("lat_rdy_tx", TX_DATA, 8'h3C);
        repeat (10) @(negedge clk);
        frame_end();

        // repeated aborts saturate the error counter
        do_reset();
        for (int k = 0; k < 20; k++) begin
            frame_start();
            send_byte(8'h10);
            frame_end();
        end
        chk("err_sat", ERR_CNT, 15);

        // byte and frame end land in the same synced cycle: byte dropped, no error
        do_reset();
        wb = wr_a.size();
        frame_start();
        send_byte(8'h05);
        send_byte(8'hA5);
        @(negedge clk); RX_BYTE = 8'h77; RX_TOGGLE = ~RX_TOGGLE; SS = 1'b1;
        repeat (10) @(negedge clk);
        chk("coll_wr_n", wr_a.size() - wb, 1);
        chk("coll_wdata", REG_WDATA, 8'hA5);
        chk("coll_busy", BUSY, 0);
        chk("coll_err", ERR_CNT, 0);

        // second byte arrives while the read is still being fetched
        do_reset();
        rb = rd_a.size();
        frame_start();
        @(negedge clk); RX_BYTE = 8'h83; RX_TOGGLE = ~RX_TOGGLE;
        @(negedge clk); RX_TOGGLE = ~RX_TOGGLE;
        repeat (20) @(negedge clk);
        frame_end();
        chk("fast_err", ERR_CNT, 1);
        chk("fast_rd_n", rd_a.size() - rb, 1);

        // reset asserted mid read burst clears everything
        do_reset();
        frame_start(); send_byte(8'h10); frame_end();
        frame_start();
        @(negedge clk); RX_BYTE = 8'h83; RX_TOGGLE = ~RX_TOGGLE;
        n = 0;
        while (n < 20 && !SPI_RDY) begin @(negedge clk); n++; end
        chk("mid_rdy_seen", SPI_RDY, 1);
        PRESETn = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", TX_DATA, 0);
        chk("mid_rst_rdy", SPI_RDY, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_err", ERR_CNT, 0);
        chk("mid_rst_addr", REG_ADDR, 0);
        chk("mid_rst_strb", {REG_WR, REG_RD}, 0);
        do_reset();

        chk("rdy_max_run", rdy_max, 2);
        chk("wr_rd_overlap", both_hi, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
